// File: rtl/attn_input_loader.sv
// Frame loader for the attention core: packs 96 stream words into key/query/value,
// then holds en until the core finishes or the watchdog expires.
module attn_input_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] key,
    output logic [511:0] query,
    output logic [511:0] value,
    output logic         en,
    input  logic         all_done,
    output logic         busy,
    output logic [6:0]   word_cnt,
    output logic         frame_done,
    output logic         frame_err,
    output logic         timeout
);

    typedef enum logic [1:0] {LOAD, RUN, RELEASE} state_t;

    state_t      state;
    logic [31:0] wd_cnt;
    logic [8:0]  slot;

    assign in_ready = (state == LOAD);
    // Element index within a bus: the low 5 bits of the word count, scaled to bit offset.
    assign slot = {word_cnt[4:0], 4'b0000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            key        <= '0;
            query      <= '0;
            value      <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
            word_cnt   <= '0;
            wd_cnt     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        case (word_cnt[6:5])
                            2'd0:    key[slot +: 16]   <= in_data;
                            2'd1:    query[slot +: 16] <= in_data;
                            default: value[slot +: 16] <= in_data;
                        endcase
                        if (in_last && word_cnt == 7'd95) begin
                            state    <= RUN;
                            en       <= 1'b1;
                            busy     <= 1'b1;
                            word_cnt <= '0;
                            wd_cnt   <= '0;
                        end else if (in_last || word_cnt == 7'd95) begin
                            frame_err <= 1'b1;
                            word_cnt  <= '0;
                        end else begin
                            word_cnt <= word_cnt + 7'd1;
                        end
                    end
                end
                RUN: begin
                    // Completion takes priority over a simultaneous watchdog expiry.
                    if (all_done) begin
                        frame_done <= 1'b1;
                        en         <= 1'b0;
                        state      <= RELEASE;
                    end else if (TIMEOUT_CYCLES != 0 && wd_cnt == TIMEOUT_CYCLES - 1) begin
                        timeout <= 1'b1;
                        en      <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                RELEASE: begin
                    state <= LOAD;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= LOAD;
                    busy  <= 1'b0;
                    en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_attn_input_loader.sv
// Directed + randomized bench for attn_input_loader with a word-array reference model.
module tb_attn_input_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] key, query, value;
    logic         en;
    logic         all_done;
    logic         busy;
    logic [6:0]   word_cnt;
    logic         frame_done, frame_err, timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Model: word n of the stream lands at element n of a 96-entry image.
    logic [15:0] mem [96];
    int          m_cnt;

    attn_input_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .key(key), .query(query), .value(value), .en(en),
        .all_done(all_done), .busy(busy), .word_cnt(word_cnt), .frame_done(frame_done),
        .frame_err(frame_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_bus(input int base);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) b[i*16 +: 16] = mem[base + i];
        return b;
    endfunction

    task automatic chk_buses(input string tag);
        chk({tag, "_key"},   key,   exp_bus(0));
        chk({tag, "_query"}, query, exp_bus(32));
        chk({tag, "_value"}, value, exp_bus(64));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 96; i++) mem[i] = '0;
        m_cnt = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 512'(in_ready), 512'(1));
        chk({tag, "_en"},       512'(en),       512'(0));
        chk({tag, "_busy"},     512'(busy),     512'(0));
        chk({tag, "_word_cnt"}, 512'(word_cnt), 512'(0));
        chk({tag, "_pulses"},   512'({frame_done, frame_err, timeout}), 512'(0));
        chk_buses(tag);
    endtask

    // Streams nwords words; in_last is raised on word index last_at (-1: never).
    // With gaps set, idle cycles carry garbage data/last that must be ignored.
    task automatic send(input int nwords, input int last_at, input bit gaps, input bit seq);
        logic [15:0] d;
        bit          lst;
        for (int n = 0; n < nwords; n++) begin
            while (gaps && $urandom_range(1, 0) == 0) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_last  = 1'b1;
                tick();
                chk("gap_word_cnt", 512'(word_cnt), 512'(m_cnt));
            end
            d   = seq ? 16'(n + 1) : 16'($urandom);
            lst = (n == last_at);
            in_valid = 1'b1;
            in_data  = d;
            in_last  = lst;
            tick();
            mem[m_cnt] = d;
            if (lst || m_cnt == 95) m_cnt = 0;
            else m_cnt++;
            if (n < nwords - 1) begin
                chk("load_word_cnt", 512'(word_cnt), 512'(m_cnt));
                chk("load_en", 512'(en), 512'(0));
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_run_entry(input string tag);
        chk({tag, "_en"},       512'(en),       512'(1));
        chk({tag, "_in_ready"}, 512'(in_ready), 512'(0));
        chk({tag, "_busy"},     512'(busy),     512'(1));
        chk({tag, "_word_cnt"}, 512'(word_cnt), 512'(0));
        chk_buses(tag);
    endtask

    initial begin
        int cycles;
        logic [511:0] k0, q0, v0;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; all_done = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // Sequential frame, all_done pulsed during LOAD must be ignored.
        all_done = 1'b1;
        send(96, 95, 1'b0, 1'b1);
        all_done = 1'b0;
        chk_run_entry("frame1");
        chk("key0",   512'(key[15:0]),      512'(16'h0001));
        chk("query0", 512'(query[15:0]),    512'(16'h0021));
        chk("value31",512'(value[511:496]), 512'(16'h0060));
        k0 = exp_bus(0); q0 = exp_bus(32); v0 = exp_bus(64);

        // Completion handshake: frame_done and en low in t+1, in_ready in t+2.
        tick(); tick();
        chk("run_hold_en", 512'(en), 512'(1));
        all_done = 1'b1;
        tick();
        all_done = 1'b0;
        chk("done_pulse", 512'({frame_done, timeout, en, in_ready, busy}), 512'(5'b10001));
        tick();
        chk("release_end", 512'({frame_done, en, in_ready, busy}), 512'(4'b0010));

        // Random frame with gaps.
        send(96, 95, 1'b1, 1'b0);
        chk_run_entry("frame2");
        all_done = 1'b1; tick(); all_done = 1'b0; tick();

        // Early in_last on word 40.
        send(41, 40, 1'b0, 1'b0);
        chk("err_early", 512'({frame_err, en, in_ready, word_cnt}), 512'({3'b101, 7'd0}));
        chk_buses("err_early_bus");
        tick();
        chk("err_pulse_len", 512'(frame_err), 512'(0));

        // Missing in_last on word 95.
        send(96, -1, 1'b0, 1'b0);
        chk("err_nolast", 512'({frame_err, en, in_ready, word_cnt}), 512'({3'b101, 7'd0}));
        tick();

        // Watchdog expiry with all_done held low.
        send(96, 95, 1'b0, 1'b0);
        chk_run_entry("frame_to");
        cycles = 0;
        while (en && cycles < 40) begin
            cycles++;
            tick();
        end
        chk("to_run_cycles", 512'(cycles), 512'(16));
        chk("to_pulse", 512'({timeout, frame_done, en, busy}), 512'(4'b1001));
        tick();
        chk("to_after", 512'({timeout, in_ready}), 512'(2'b01));

        // all_done coincident with watchdog expiry: only frame_done.
        send(96, 95, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk("race_en_before", 512'(en), 512'(1));
        all_done = 1'b1;
        tick();
        all_done = 1'b0;
        chk("race_pulse", 512'({frame_done, timeout, en}), 512'(3'b100));
        tick();
        chk("race_after", 512'({frame_done, timeout, in_ready}), 512'(3'b001));

        // Gap-free and gapped sequential frames produce identical buses.
        send(96, 95, 1'b1, 1'b1);
        chk("gapped_key",   key,   k0);
        chk("gapped_query", query, q0);
        chk("gapped_value", value, v0);
        all_done = 1'b1; tick(); all_done = 1'b0; tick();

        // Reset mid-frame after 50 words.
        send(50, -1, 1'b0, 1'b0);
        chk("mid_word_cnt", 512'(word_cnt), 512'(50));
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        chk_reset_state("rst_load");

        // Reset during RUN.
        send(96, 95, 1'b0, 1'b0);
        chk_run_entry("frame_rst");
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        chk_reset_state("rst_run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
